// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for the pipe_stage_buf slice: default payload width, the
// RISC-V NOP bubble payload and the occupancy-count width macro.
`ifndef PIPE_STAGE_BUF_PKG_SV
`define PIPE_STAGE_BUF_PKG_SV

`define BUS_PIPE_CNT(depth) ($clog2((depth) + 1))

package pipe_stage_buf_pkg;

  localparam int DATA_W_DEFAULT = 256;
  localparam int DEPTH_DEFAULT  = 2;

  // ADDI x0,x0,0 in the low instruction slot, all other payload fields zero.
  localparam logic [31:0]               RV_ADDI_X0_X0_0 = 32'h0000_0013;
  localparam logic [DATA_W_DEFAULT-1:0] PIPE_BUBBLE_NOP =
    DATA_W_DEFAULT'(RV_ADDI_X0_X0_0);

  // A single-entry buffer still needs a one-bit pointer to stay legal.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`endif

// File: rtl/pipe_stage_buf_if.sv
// Upstream/downstream handshake bundle for pipe_stage_buf; the buffer takes
// the slave modport, the neighbouring stages the master modport.
interface pipe_stage_buf_if
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = `BUS_PIPE_CNT(DEPTH_DEFAULT)
);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [CNT_W-1:0]  count_o;
  logic [31:0]       stall_cnt_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, count_o, stall_cnt_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, count_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_stage_buf_mem.sv
// pipe_stage_mem: DEPTH x DATA_W register array, one synchronous write port
// and one asynchronous read port.
module pipe_stage_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: payload entries carry no reset; validity lives in the parent's count,
  // so stale contents are never observed and the array stays plain flops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready inter-stage buffer with DEPTH-entry skid FIFO,
// hold_n stall, synchronous flush and bubble output. Optional stall counter
// is enabled by defining PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEFAULT,
  parameter int                DEPTH      = DEPTH_DEFAULT,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold_n,
  input  logic            flush_i,
  pipe_stage_buf_if.slave bus
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = `BUS_PIPE_CNT(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t              rd_ptr;
  ptr_t              wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;

  // Wrap compares against DEPTH-1 so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready comes from registered occupancy only: a full buffer popping this
  // cycle still refuses, and the freed slot is offered next cycle.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = bus.in_valid_i & in_ready;
  assign pop       = out_valid & bus.out_ready_i & hold_n;
  assign wr_en     = push & rst_n & ~flush_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  pipe_stage_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr),
    .wr_data (bus.in_data_i),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = out_valid ? rd_data : BUBBLE_VAL;
  assign bus.count_o     = count;

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0] stall_cnt;
  logic        stall_cyc;

  assign stall_cyc = out_valid & (~bus.out_ready_i | ~hold_n);

  // Cleared by reset only; a flush keeps the accumulated stall history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_cyc && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
`else
  assign bus.stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed vector table on a DEPTH=2
// instance plus a scoreboarded wrap/reset sequence on a DEPTH=3 instance.
module tb_pipe_stage_buf;

`ifdef PIPE_STAGE_BUF_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  localparam logic [7:0] BUB_A = 8'hEE;
  localparam logic [7:0] BUB_B = 8'h13;

  logic clk = 1'b0;
  logic rst_n;
  logic hold_n;
  logic flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_buf_if #(.DATA_W(8), .CNT_W(2)) ifa ();
  pipe_stage_buf_if #(.DATA_W(8), .CNT_W(2)) ifb ();

  pipe_stage_buf #(.DATA_W(8), .DEPTH(2), .BUBBLE_VAL(BUB_A)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_n  (hold_n),
    .flush_i (flush),
    .bus     (ifa.slave)
  );

  pipe_stage_buf #(.DATA_W(8), .DEPTH(3), .BUBBLE_VAL(BUB_B)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_n  (hold_n),
    .flush_i (flush),
    .bus     (ifb.slave)
  );

  typedef struct packed {
    logic        iv;
    logic [7:0]  id;
    logic        ordy;
    logic        hold;
    logic        fl;
    logic        e_rdy;
    logic        e_vld;
    logic [7:0]  e_data;
    logic [1:0]  e_cnt;
    logic [31:0] e_stall;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic iv, input logic [7:0] id,
                              input logic ordy, input logic hold, input logic fl,
                              input logic e_rdy, input logic e_vld,
                              input logic [7:0] e_data, input logic [1:0] e_cnt,
                              input logic [31:0] e_stall);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.hold = hold; v.fl = fl;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_cnt = e_cnt;
    v.e_stall = PERF_EN ? e_stall : 32'd0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ifa.in_valid_i  = vecs[i].iv;
      ifa.in_data_i   = vecs[i].id;
      ifa.out_ready_i = vecs[i].ordy;
      hold_n          = vecs[i].hold;
      flush           = vecs[i].fl;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d in_ready", i),  32'(ifa.in_ready_o),  32'(vecs[i].e_rdy));
      check($sformatf("v%0d out_valid", i), 32'(ifa.out_valid_o), 32'(vecs[i].e_vld));
      check($sformatf("v%0d out_data", i),  32'(ifa.out_data_o),  32'(vecs[i].e_data));
      check($sformatf("v%0d count", i),     32'(ifa.count_o),     32'(vecs[i].e_cnt));
      check($sformatf("v%0d stall_cnt", i), ifa.stall_cnt_o,      vecs[i].e_stall);
    end
  endtask

  // Scoreboard for the DEPTH=3 instance.
  logic [7:0] q [$];
  logic [7:0] next_b = 8'h40;

  task automatic step_b(input logic iv, input logic ordy, input string tag);
    logic push_e;
    logic pop_e;
    ifb.in_valid_i  = iv;
    ifb.in_data_i   = next_b;
    ifb.out_ready_i = ordy;
    #1;
    check({tag, " in_ready"}, 32'(ifb.in_ready_o), 32'(q.size() < 3));
    push_e = iv && (q.size() < 3);
    pop_e  = ordy && (q.size() > 0);
    @(posedge clk);
    @(negedge clk);
    if (pop_e) void'(q.pop_front());
    if (push_e) begin
      q.push_back(next_b);
      next_b = next_b + 8'd1;
    end
    check({tag, " out_valid"}, 32'(ifb.out_valid_o), 32'(q.size() > 0));
    check({tag, " out_data"},  32'(ifb.out_data_o),  32'((q.size() > 0) ? q[0] : BUB_B));
    check({tag, " count"},     32'(ifb.count_o),     32'(q.size()));
  endtask

  logic [31:0] stall_before;

  initial begin
    // Test 1: streaming, count never exceeds 1.
    vecs[0]  = mk(1, 8'hA1, 1, 1, 0,  1, 1, 8'hA1, 2'd1, 0);
    vecs[1]  = mk(1, 8'hA2, 1, 1, 0,  1, 1, 8'hA2, 2'd1, 0);
    vecs[2]  = mk(0, 8'h00, 1, 1, 0,  1, 0, BUB_A, 2'd0, 0);
    // Test 2: fill with downstream blocked; 0xB3 refused.
    vecs[3]  = mk(1, 8'hB1, 0, 1, 0,  1, 1, 8'hB1, 2'd1, 0);
    vecs[4]  = mk(1, 8'hB2, 0, 1, 0,  0, 1, 8'hB1, 2'd2, 1);
    vecs[5]  = mk(1, 8'hB3, 0, 1, 0,  0, 1, 8'hB1, 2'd2, 2);
    // Test 3: full with pop -> no pass-through, 0xB3 taken a cycle later.
    vecs[6]  = mk(1, 8'hB3, 1, 1, 0,  1, 1, 8'hB2, 2'd1, 2);
    vecs[7]  = mk(1, 8'hB3, 1, 1, 0,  1, 1, 8'hB3, 2'd1, 2);
    vecs[8]  = mk(0, 8'h00, 1, 1, 0,  1, 0, BUB_A, 2'd0, 2);
    // Test 4: refill, then hold with out_ready high for 3 cycles.
    vecs[9]  = mk(1, 8'hD1, 0, 1, 0,  1, 1, 8'hD1, 2'd1, 2);
    vecs[10] = mk(1, 8'hD2, 0, 1, 0,  0, 1, 8'hD1, 2'd2, 3);
    vecs[11] = mk(0, 8'h00, 1, 0, 0,  0, 1, 8'hD1, 2'd2, 4);
    vecs[12] = mk(0, 8'h00, 1, 0, 0,  0, 1, 8'hD1, 2'd2, 5);
    vecs[13] = mk(0, 8'h00, 1, 0, 0,  0, 1, 8'hD1, 2'd2, 6);
    // Test 5: flush with a push in the flush cycle; counter survives flush.
    vecs[14] = mk(1, 8'hC1, 0, 1, 1,  1, 0, BUB_A, 2'd0, 7);
    vecs[15] = mk(0, 8'h00, 1, 1, 0,  1, 0, BUB_A, 2'd0, 7);
    // Flush together with hold: flush wins.
    vecs[16] = mk(1, 8'hE1, 0, 1, 0,  1, 1, 8'hE1, 2'd1, 7);
    vecs[17] = mk(0, 8'h00, 0, 0, 1,  1, 0, BUB_A, 2'd0, 8);

    rst_n = 1'b0; hold_n = 1'b1; flush = 1'b0;
    ifa.in_valid_i = 1'b0; ifa.in_data_i = '0; ifa.out_ready_i = 1'b0;
    ifb.in_valid_i = 1'b0; ifb.in_data_i = '0; ifb.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst in_ready",  32'(ifa.in_ready_o),  32'd1);
    check("rst out_valid", 32'(ifa.out_valid_o), 32'd0);
    check("rst out_data",  32'(ifa.out_data_o),  32'(BUB_A));
    check("rst count",     32'(ifa.count_o),     32'd0);
    check("rst stall_cnt", ifa.stall_cnt_o,      32'd0);
    check("rst b out_data", 32'(ifb.out_data_o), 32'(BUB_B));
    rst_n = 1'b1;

    run_vecs(0, 10);
    stall_before = ifa.stall_cnt_o;
    run_vecs(11, 13);
    check("hold stall delta", ifa.stall_cnt_o - stall_before, PERF_EN ? 32'd3 : 32'd0);
    run_vecs(14, 17);
    ifa.in_valid_i = 1'b0; hold_n = 1'b1; flush = 1'b0;

    // Test 6: DEPTH=3 random interleave across pointer wrap.
    for (int i = 0; i < 24; i++) begin
      step_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end
    step_b(1'b1, 1'b0, "pre_rst0");
    step_b(1'b1, 1'b0, "pre_rst1");

    // Reset mid-stream with a push offered.
    rst_n = 1'b0;
    ifb.in_valid_i = 1'b1; ifb.in_data_i = 8'h99; ifb.out_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid rst in_ready",  32'(ifb.in_ready_o),  32'd1);
    check("mid rst out_valid", 32'(ifb.out_valid_o), 32'd0);
    check("mid rst out_data",  32'(ifb.out_data_o),  32'(BUB_B));
    check("mid rst count",     32'(ifb.count_o),     32'd0);
    check("mid rst stall a",   ifa.stall_cnt_o,      32'd0);
    check("mid rst stall b",   ifb.stall_cnt_o,      32'd0);
    rst_n = 1'b1;
    q.delete();
    step_b(1'b1, 1'b0, "post_rst0");
    step_b(1'b1, 1'b1, "post_rst1");
    step_b(1'b0, 1'b1, "post_rst2");
    step_b(1'b0, 1'b1, "post_rst3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
